// File: rtl/prog_uart_rx.sv
// 8N1 UART receiver with a programmable bit period and a small receive FIFO.
// Mid-bit sampling is done by a down-counter that starts at half a bit after the start edge.
module prog_uart_rx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        rd_en_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        frame_err_o,
  output logic        overflow_o
);

  // state     | meaning
  // IDLE      | line idle, waiting for a falling edge on rx_s
  // START     | half a bit in, confirming the start bit is still low
  // DATA      | sampling 8 data bits LSB-first, one per tick
  // STOP      | sampling the stop bit, pushing or flagging the byte
  // WAIT_IDLE | after a framing error, wait for the line to go high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic             r_rx_meta;
  logic             r_rx_s;
  state_t           r_state;
  logic [15:0]      r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic             r_overflow;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_mem [FIFO_DEPTH];

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_tick;
  logic        w_stop_good;
  logic        w_stop_bad;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_state != S_IDLE) && (r_bit_cnt == 16'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_tick ? FULL_LOAD : (r_bit_cnt - 16'd1);
    end
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = HALF_LOAD;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_stop_good = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      if (w_stop_bad) begin
        r_frame_err <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = rd_en_i && !w_empty;
  assign w_push  = w_stop_good && (!w_full || w_pop);
  assign w_drop  = w_stop_good && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  assign rd_valid_o  = !w_empty;
  assign rd_data_o   = w_empty ? 32'hFFFF_FFFF : {24'h0, r_mem[r_rd_ptr]};
  assign busy_o      = (r_state != S_IDLE);
  assign frame_err_o = r_frame_err;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_prog_uart_rx.sv
// Bench for prog_uart_rx: directed frames plus random traffic against a queue-based model.
// Stop-bit tick is predicted as 2 sync + 1 detect + half a bit + 9 bits after the start edge.
module tb_prog_uart_rx;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        frame_err;
  logic        overflow;

  int n_vec  = 0;
  int n_miss = 0;

  byte unsigned q[$];
  bit m_ovf;
  bit m_ferr;

  prog_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_i(rx),
    .rd_en_i(rd_en),
    .rd_data_o(rd_data),
    .rd_valid_o(rd_valid),
    .busy_o(busy),
    .frame_err_o(frame_err),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_data();
    if (q.size() == 0) return 32'hFFFF_FFFF;
    return {24'h0, q[0]};
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ":valid"}, {31'h0, rd_valid}, {31'h0, q.size() != 0});
    check_val({tag, ":data"}, rd_data, exp_data());
    check_val({tag, ":ovf"}, {31'h0, overflow}, {31'h0, m_ovf});
    check_val({tag, ":ferr"}, {31'h0, frame_err}, {31'h0, m_ferr});
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    step(2);
    rst = 1'b0;
    q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    check_val("reset:busy", {31'h0, busy}, 32'h0);
    check_outputs("reset");
  endtask

  task automatic send_frame(input byte unsigned b, input bit stop_ok, input bit pop_at_stop);
    rx = 1'b0;
    step(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CLK_DIV);
    end
    rx = stop_ok;
    step(CLK_DIV / 2 + 2);
    check_val("pre_stop:valid", {31'h0, rd_valid}, {31'h0, q.size() != 0});
    check_val("pre_stop:busy", {31'h0, busy}, 32'h1);
    if (pop_at_stop) begin
      check_val("pre_stop:data", rd_data, exp_data());
      rd_en = 1'b1;
    end
    step(1);
    rd_en = 1'b0;
    if (pop_at_stop && q.size() != 0) void'(q.pop_front());
    if (stop_ok) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    check_outputs("stop");
    step(CLK_DIV - CLK_DIV / 2 - 3);
    if (!stop_ok) begin
      check_val("wait_idle:busy", {31'h0, busy}, 32'h1);
    end
    rx = 1'b1;
    if (!stop_ok) step(4);
    check_val("frame_end:busy", {31'h0, busy}, 32'h0);
  endtask

  task automatic pop_one();
    check_val("pop:head", rd_data, exp_data());
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_outputs("pop");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned v;
    int unsigned r;
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    step(1);
    do_reset();

    // single byte with timing check, then pop to empty
    send_frame(8'hA5, 1'b1, 1'b0);
    check_val("a5:data", rd_data, 32'h0000_00A5);
    pop_one();
    check_val("a5:empty", rd_data, 32'hFFFF_FFFF);

    // overflow on the fifth byte with no reads
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_val("ovf:flag", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 4; i++) pop_one();

    // framing error with the line held low past the stop bit
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0);
    check_val("ferr:flag", {31'h0, frame_err}, 32'h1);
    check_val("ferr:valid", {31'h0, rd_valid}, 32'h0);

    // start glitch shorter than half a bit
    do_reset();
    rx = 1'b0;
    step(5);
    check_val("glitch:busy_hi", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    step(20);
    check_val("glitch:busy_lo", {31'h0, busy}, 32'h0);
    check_outputs("glitch");

    // full FIFO with a pop on the stop tick
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
    send_frame(8'h77, 1'b1, 1'b1);
    check_val("fullpop:ovf", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 4; i++) pop_one();

    // empty FIFO with a pop on the stop tick
    do_reset();
    send_frame(8'h42, 1'b1, 1'b1);
    check_val("emptypop:data", rd_data, 32'h0000_0042);
    pop_one();

    // reset during data bit 3, then a clean frame
    do_reset();
    v  = 8'hC3;
    rx = 1'b0;
    step(CLK_DIV);
    for (int i = 0; i < 3; i++) begin
      rx = v[i];
      step(CLK_DIV);
    end
    rx = v[3];
    step(6);
    rst = 1'b1;
    rx  = 1'b1;
    step(1);
    rst = 1'b0;
    q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    check_val("midrst:busy", {31'h0, busy}, 32'h0);
    step(30);
    check_outputs("midrst");
    send_frame(8'h5A, 1'b1, 1'b0);
    check_val("midrst:5a", rd_data, 32'h0000_005A);
    pop_one();

    // random traffic
    do_reset();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      v = 8'($urandom_range(0, 255));
      if (r < 6) begin
        send_frame(v, 1'b1, $urandom_range(0, 3) == 0);
      end else if (r < 7) begin
        send_frame(v, 1'b0, 1'b0);
      end else begin
        r = $urandom_range(1, 3);
        for (int k = 0; k < int'(r); k++) pop_one();
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) pop_one();
    check_val("final:empty", rd_data, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prog_uart_rx.md
PROG_UART_RX -- requirements
Module: prog_uart_rx

Interface
REQ-001 Parameter CLK_DIV, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous reset, active-high.
REQ-005 rx_i  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 rd_en_i  input  1  pop request for the FIFO head.
REQ-007 rd_data_o  output  32  {24'h0, head byte} when FIFO non-empty, else 32'hFFFF_FFFF.
REQ-008 rd_valid_o  output  1  high when the FIFO is non-empty.
REQ-009 busy_o  output  1  high whenever the receive FSM is not in IDLE.
REQ-010 frame_err_o  output  1  sticky; set on a stop-bit error, cleared only by reset.
REQ-011 overflow_o  output  1  sticky; set when a good byte is dropped because the FIFO is full, cleared only by reset.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer (rx_s); both flops reset to 1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE: when rx_s==0, go to START and load bit counter with CLK_DIV/2-1 (integer division).
REQ-015 Bit counter SHALL decrement once per cycle outside IDLE; "tick" is defined as the counter equal to 0, at which point it reloads with CLK_DIV-1.
REQ-016 START on tick: if rx_s==0, go to DATA with bit index 0; if rx_s==1 (glitch), return to IDLE with no flag or FIFO change.
REQ-017 DATA on tick: shift rx_s into the MSB of an 8-bit right-shifting register (LSB-first on the wire) and increment bit index; after the 8th sample, go to STOP.
REQ-018 STOP on tick, rx_s==1: push the byte if FIFO not full, else drop it and set overflow_o; go to IDLE.
REQ-019 STOP on tick, rx_s==0: discard the byte, set frame_err_o, go to WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until rx_s==1, then go to IDLE; no start detection in this state.
REQ-021 A pushed byte SHALL appear on rd_data_o with rd_valid_o=1 in the cycle after the stop-bit tick edge.
REQ-022 rd_data_o and rd_valid_o SHALL be combinational from FIFO head and count; no read latency.
REQ-023 rd_en_i with FIFO empty SHALL be ignored; rd_en_i with FIFO non-empty pops the head at the clock edge.
REQ-024 Simultaneous push and pop when FIFO full: both take effect, count unchanged, overflow_o not set.
REQ-025 Simultaneous push and pop when FIFO empty: the pop is ignored; after the edge, count is 1 holding the new byte.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-027 Byte order out of the FIFO SHALL equal order of reception.

Reset
REQ-028 On rst_i=1 at a clock edge: FSM to IDLE; counters, pointers and count to 0; sync flops to 1; frame_err_o and overflow_o to 0.
REQ-029 Resulting output values: rd_valid_o=0, rd_data_o=32'hFFFF_FFFF, busy_o=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame without pushing.
REQ-031 After that reset, if rx_i is low, the remaining low bits SHALL be treated as a new start bit; no extra guarding is required.
REQ-032 FIFO contents need no reset; they are unobservable while count==0.

Verification
REQ-033 CLK_DIV=16: send 0xA5 8N1 -> rd_valid_o rises one cycle after the stop tick, rd_data_o=32'h0000_00A5; rd_en_i pulse -> rd_data_o=32'hFFFF_FFFF.
REQ-034 CLK_DIV=16, FIFO_DEPTH=4, no reads: send 0x01..0x05 -> 4 entries 0x01..0x04, overflow_o=1; popping yields 0x01,0x02,0x03,0x04.
REQ-035 Send 0x3C with stop bit held low -> frame_err_o=1, rd_valid_o stays 0, busy_o stays 1 until rx_i returns high.
REQ-036 rx_i low for 5 cycles (CLK_DIV=16) -> START returns to IDLE, no push, no flags.
REQ-037 FIFO full with rd_en_i=1 during the stop-bit tick of byte 0x77 -> count stays 4, overflow_o=0, 0x77 is read last.
REQ-038 rst_i=1 during DATA bit 3 of 0xC3 -> no push; busy_o=0 the cycle after reset; a following 0x5A is received correctly.
